rv32_alu_operand_stage: RTL and testbench
=========================================

Name: rv32_alu_operand_stage

Overview:
- Registered issue stage directly upstream of the RV32 ALU: takes decoded instructions from decode, selects and conditions the two ALU operands, and presents them with the ALU opcode.
- Decouples decode from execute with a valid/ready handshake and a 2-entry skid buffer, so decode sees no combinational ready path from execute.
- Carries per-hart writeback and store-data sideband and supports per-hart flush for the barrel pipeline.

Parameters:
- XLEN, 32, datapath width; the ALU operates on 32-bit registers.
- ALU_OP_W, 5, width of the ALU opcode field, passed through unchanged.
- HART_ID_W, 3, hart index width; 8 harts by default.
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  decode offers an instruction.
- in_ready  out  1  stage can accept; registered.
- in_rs1_data  in  XLEN  rs1 register-file value.
- in_rs2_data  in  XLEN  rs2 register-file value.
- in_imm  in  XLEN  sign-extended immediate.
- in_pc  in  XLEN  instruction PC.
- in_op1_sel  in  2  0 = rs1, 1 = pc, 2 or 3 = zero.
- in_op2_sel  in  2  0 = rs2, 1 = imm, 2 = constant 4, 3 = zero.
- in_is_shift  in  1  opcode is SLL/SRL/SRA.
- in_alu_op  in  ALU_OP_W  ALU opcode.
- in_hart_id  in  HART_ID_W  issuing hart.
- in_rd  in  RD_W  destination register.
- in_rd_we  in  1  writeback enable.
- flush_valid  in  1  flush request.
- flush_hart  in  HART_ID_W  hart to flush.
- out_valid  out  1  operands valid to ALU/execute.
- out_ready  in  1  execute accepts.
- alu_rs1  out  XLEN  ALU operand 1.
- alu_rs2  out  XLEN  ALU operand 2.
- alu_opcode  out  ALU_OP_W  ALU opcode.
- out_store_data  out  XLEN  unmodified in_rs2_data, for stores.
- out_hart_id  out  HART_ID_W  sideband.
- out_rd  out  RD_W  sideband.
- out_rd_we  out  1  sideband.

Behaviour:
- Storage: main register (drives outputs) and skid register, each with a valid bit.
  - Every output is taken directly from a flop; there are no combinational paths from in_* or out_ready to any output.
- Reset (rst_n low at a clock edge):
  - out_valid = 0 and both valid bits = 0.
  - All data and sideband outputs = 0.
  - in_ready = 1 from the first cycle after reset deasserts.
  - Reset mid-operation discards all held entries with no output beat.
- Operand conditioning happens at capture time:
  - op1 and op2 are selected per the sel encodings above.
  - If in_is_shift = 1, op2 is replaced by {27'b0, op2[4:0]}; the ALU shifts by the full rs2 value, so masking is mandatory here.
  - No other arithmetic is performed in this stage.
- Handshake:
  - Input accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - in_ready = !skid_valid, registered.
- Latency: an instruction accepted in cycle N drives out_valid in cycle N+1 when the main register is empty or transfers in cycle N.
- Capture rules per cycle:
  - Main empty, or main transfers: the input goes to main. If skid is valid, skid moves to main and the input goes to skid instead.
  - Main full and not transferring, accept asserted: the input goes to skid, and in_ready is 0 next cycle.
  - Skid full and main transfers with no accept: skid moves to main, and in_ready is 1 next cycle.
- Ordering: strict FIFO across both entries; never reorder.
- Full condition: both entries valid means in_ready = 0. in_valid is ignored while in_ready = 0; decode must hold its beat.
- Flush (flush_valid = 1 in cycle N):
  - Main and skid entries with hart_id == flush_hart are invalidated at the edge ending cycle N.
  - An input beat with in_hart_id == flush_hart in cycle N is dropped, but still counts as accepted by the handshake.
  - A main-entry transfer completing in cycle N stands; execute has consumed it, and only entries remaining after the transfer are flushed.
  - If main is flushed while skid survives, skid moves to main.
  - Entries of other harts are unaffected.
- Data outputs hold their last value when out_valid = 0.
  - Verification must check data outputs only when out_valid = 1.

Test Plan:
- Single beat: rs1 = 0x10, imm = 0xFFFFFFF0, op2_sel = 1, alu_op = ADD, out_ready = 1 -> one cycle later out_valid = 1, alu_rs1 = 0x10, alu_rs2 = 0xFFFFFFF0; out_valid = 0 the following cycle.
- Shift mask: rs1 = 1, rs2 = 0x00000024, in_is_shift = 1, op2_sel = 0 -> alu_rs2 = 0x4; the ALU then yields 0x10, not 0.
- PC + 4: op1_sel = 1, op2_sel = 2, pc = 0x80000100 -> alu_rs1 = 0x80000100, alu_rs2 = 4.
- Backpressure:
  - Stimulus: out_ready = 0 while beats A, B, C are offered back-to-back.
  - Required: A held on the outputs, B in skid, in_ready = 0, C held by decode.
  - Then raise out_ready -> outputs A, B, C in order with no loss or duplication.
- Flush:
  - Stimulus: main = hart 2, skid = hart 5, out_ready = 0; flush_valid with flush_hart = 2.
  - Required: next cycle the outputs show the hart 5 entry and in_ready = 1.
  - Flushing hart 5 in the same setup -> main (hart 2) is kept and skid is emptied.
- Reset mid-stream: both entries full, rst_n = 0 for one cycle -> out_valid = 0, all outputs 0, in_ready = 1 after release; no stale beat appears.

Source files
------------

// File: rtl/rv32_alu_operand_stage.sv
// Issue stage in front of the RV32 ALU: selects and conditions both operands,
// buffers up to two instructions (main + skid) and supports per-hart flush.
module rv32_alu_operand_stage #(
  parameter int XLEN      = 32,
  parameter int ALU_OP_W  = 5,
  parameter int HART_ID_W = 3,
  parameter int RD_W      = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_rs1_data,
  input  logic [XLEN-1:0]      in_rs2_data,
  input  logic [XLEN-1:0]      in_imm,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [1:0]           in_op1_sel,
  input  logic [1:0]           in_op2_sel,
  input  logic                 in_is_shift,
  input  logic [ALU_OP_W-1:0]  in_alu_op,
  input  logic [HART_ID_W-1:0] in_hart_id,
  input  logic [RD_W-1:0]      in_rd,
  input  logic                 in_rd_we,
  input  logic                 flush_valid,
  input  logic [HART_ID_W-1:0] flush_hart,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      alu_rs1,
  output logic [XLEN-1:0]      alu_rs2,
  output logic [ALU_OP_W-1:0]  alu_opcode,
  output logic [XLEN-1:0]      out_store_data,
  output logic [HART_ID_W-1:0] out_hart_id,
  output logic [RD_W-1:0]      out_rd,
  output logic                 out_rd_we
);

  localparam int SHAMT_W = 5;

  typedef struct packed {
    logic [XLEN-1:0]      op1;
    logic [XLEN-1:0]      op2;
    logic [XLEN-1:0]      store_data;
    logic [ALU_OP_W-1:0]  alu_op;
    logic [HART_ID_W-1:0] hart_id;
    logic [RD_W-1:0]      rd;
    logic                 rd_we;
  } entry_t;

  entry_t r_main, r_skid;
  logic   r_main_valid, r_skid_valid, r_in_ready;

  entry_t          w_in_entry, w_main_next, w_skid_next;
  logic [XLEN-1:0] w_op1, w_op2_raw;
  logic            w_accept, w_xfer;
  logic            w_main_keep, w_skid_keep, w_in_keep;
  logic            w_main_next_valid, w_skid_next_valid;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_op1     = '0;
    w_op2_raw = '0;
    case (in_op1_sel)
      2'd0:    w_op1 = in_rs1_data;
      2'd1:    w_op1 = in_pc;
      default: w_op1 = '0;
    endcase
    case (in_op2_sel)
      2'd0:    w_op2_raw = in_rs2_data;
      2'd1:    w_op2_raw = in_imm;
      2'd2:    w_op2_raw = XLEN'(4);
      default: w_op2_raw = '0;
    endcase

    w_in_entry            = '0;
    w_in_entry.op1        = w_op1;
    // The ALU shifts by the whole operand, so the shift amount is trimmed here.
    w_in_entry.op2        = in_is_shift ? {{(XLEN-SHAMT_W){1'b0}}, w_op2_raw[SHAMT_W-1:0]}
                                        : w_op2_raw;
    w_in_entry.store_data = in_rs2_data;
    w_in_entry.alu_op     = in_alu_op;
    w_in_entry.hart_id    = in_hart_id;
    w_in_entry.rd         = in_rd;
    w_in_entry.rd_we      = in_rd_we;
  end

  // A transfer completing this cycle stands even if its hart is being flushed.
  assign w_accept    = in_valid & r_in_ready;
  assign w_xfer      = r_main_valid & out_ready;
  assign w_main_keep = r_main_valid & ~w_xfer &
                       ~(flush_valid & (r_main.hart_id == flush_hart));
  assign w_skid_keep = r_skid_valid & ~(flush_valid & (r_skid.hart_id == flush_hart));
  assign w_in_keep   = w_accept & ~(flush_valid & (in_hart_id == flush_hart));

  // Surviving entries are compacted in age order: main, then skid, then the new beat.
  always_comb begin
    w_main_next       = r_main;
    w_skid_next       = r_skid;
    w_main_next_valid = 1'b1;
    w_skid_next_valid = 1'b0;
    if (w_main_keep) begin
      if (w_skid_keep) begin
        w_skid_next_valid = 1'b1;
      end else if (w_in_keep) begin
        w_skid_next       = w_in_entry;
        w_skid_next_valid = 1'b1;
      end
    end else if (w_skid_keep) begin
      w_main_next = r_skid;
      if (w_in_keep) begin
        w_skid_next       = w_in_entry;
        w_skid_next_valid = 1'b1;
      end
    end else if (w_in_keep) begin
      w_main_next = w_in_entry;
    end else begin
      w_main_next_valid = 1'b0;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
      // NOTE: payload registers are reset too because the outputs must read zero after reset.
      r_main       <= '0;
      r_skid       <= '0;
    end else begin
      r_main_valid <= w_main_next_valid;
      r_skid_valid <= w_skid_next_valid;
      r_in_ready   <= ~w_skid_next_valid;
      if (w_main_next_valid) r_main <= w_main_next;
      if (w_skid_next_valid) r_skid <= w_skid_next;
    end
  end

  assign in_ready       = r_in_ready;
  assign out_valid      = r_main_valid;
  assign alu_rs1        = r_main.op1;
  assign alu_rs2        = r_main.op2;
  assign alu_opcode     = r_main.alu_op;
  assign out_store_data = r_main.store_data;
  assign out_hart_id    = r_main.hart_id;
  assign out_rd         = r_main.rd;
  assign out_rd_we      = r_main.rd_we;

endmodule

// File: tb/tb_rv32_alu_operand_stage.sv
// Self-checking bench for rv32_alu_operand_stage: directed scenarios plus a
// randomized run against a queue-based model of the stage.
module tb_rv32_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
  logic [1:0]  in_op1_sel, in_op2_sel;
  logic        in_is_shift;
  logic [4:0]  in_alu_op;
  logic [2:0]  in_hart_id;
  logic [4:0]  in_rd;
  logic        in_rd_we;
  logic        flush_valid;
  logic [2:0]  flush_hart;
  logic        out_valid, out_ready;
  logic [31:0] alu_rs1, alu_rs2, out_store_data;
  logic [4:0]  alu_opcode;
  logic [2:0]  out_hart_id;
  logic [4:0]  out_rd;
  logic        out_rd_we;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rv32_alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_pc(in_pc),
    .in_op1_sel(in_op1_sel), .in_op2_sel(in_op2_sel),
    .in_is_shift(in_is_shift), .in_alu_op(in_alu_op),
    .in_hart_id(in_hart_id), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .flush_valid(flush_valid), .flush_hart(flush_hart),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_opcode(alu_opcode),
    .out_store_data(out_store_data), .out_hart_id(out_hart_id),
    .out_rd(out_rd), .out_rd_we(out_rd_we)
  );

  typedef struct {
    logic [31:0] op1, op2, store;
    logic [4:0]  op;
    logic [2:0]  hart;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  exp_t q[$];

  function automatic exp_t make_exp();
    exp_t e;
    e.op1 = (in_op1_sel == 2'd0) ? in_rs1_data : (in_op1_sel == 2'd1) ? in_pc : 32'd0;
    case (in_op2_sel)
      2'd0:    e.op2 = in_rs2_data;
      2'd1:    e.op2 = in_imm;
      2'd2:    e.op2 = 32'd4;
      default: e.op2 = 32'd0;
    endcase
    if (in_is_shift) e.op2 = e.op2 % 32;
    e.store = in_rs2_data;
    e.op    = in_alu_op;
    e.hart  = in_hart_id;
    e.rd    = in_rd;
    e.we    = in_rd_we;
    return e;
  endfunction

  // One clock: the model follows the stage as an in-order queue of at most two.
  task automatic tick();
    exp_t kept[$];
    bit   acc;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
    end else begin
      acc = in_valid && (q.size() < 2);
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (flush_valid) begin
        foreach (q[i]) if (q[i].hart != flush_hart) kept.push_back(q[i]);
        q = kept;
      end
      if (acc && !(flush_valid && in_hart_id == flush_hart)) q.push_back(make_exp());
    end
    #1;
  endtask

  task automatic drive_beat(input logic [31:0] rs1, rs2, imm, pc,
                            input logic [1:0] s1, s2, input logic sh,
                            input logic [4:0] op, input logic [2:0] hart);
    in_valid = 1'b1; in_rs1_data = rs1; in_rs2_data = rs2; in_imm = imm; in_pc = pc;
    in_op1_sel = s1; in_op2_sel = s2; in_is_shift = sh; in_alu_op = op;
    in_hart_id = hart; in_rd = 5'd7; in_rd_we = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush_valid = 1'b0; flush_hart = '0;
    drive_beat(32'h0, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0, 5'd0, 3'd0);
    in_valid = 1'b0;
    tick(); tick();
    n_checks++;
    if (out_valid !== 1'b0 || alu_rs1 !== 32'h0 || alu_rs2 !== 32'h0 || out_store_data !== 32'h0 ||
        alu_opcode !== 5'h0 || out_hart_id !== 3'h0 || out_rd !== 5'h0 || out_rd_we !== 1'b0)
      begin n_fail++; $display("FAIL reset_outputs: valid=%b rs1=%h rs2=%h exp all zero", out_valid, alu_rs1, alu_rs2); end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin n_fail++; $display("FAIL reset_release: in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid); end
  endtask

  task automatic test_single_beat();
    out_ready = 1'b1;
    drive_beat(32'h10, 32'h1234_5678, 32'hFFFF_FFF0, 32'h0, 2'd0, 2'd1, 1'b0, 5'd0, 3'd1);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || alu_rs1 !== 32'h10 || alu_rs2 !== 32'hFFFF_FFF0)
      begin n_fail++; $display("FAIL single_beat: v=%b rs1=%h rs2=%h exp 1 00000010 fffffff0", out_valid, alu_rs1, alu_rs2); end
    n_checks++;
    if (out_store_data !== 32'h1234_5678 || out_hart_id !== 3'd1 || out_rd !== 5'd7 || out_rd_we !== 1'b1)
      begin n_fail++; $display("FAIL single_sideband: sd=%h hart=%0d rd=%0d we=%b", out_store_data, out_hart_id, out_rd, out_rd_we); end
    tick();
    n_checks++;
    if (out_valid !== 1'b0)
      begin n_fail++; $display("FAIL single_drain: out_valid=%b exp 0", out_valid); end
  endtask

  task automatic test_shift_mask();
    logic [31:0] shifted;
    out_ready = 1'b1;
    drive_beat(32'h1, 32'h24, 32'h0, 32'h0, 2'd0, 2'd0, 1'b1, 5'd1, 3'd0);
    tick();
    in_valid = 1'b0;
    shifted = alu_rs1 << alu_rs2;
    n_checks++;
    if (out_valid !== 1'b1 || alu_rs2 !== 32'h4 || out_store_data !== 32'h24)
      begin n_fail++; $display("FAIL shift_mask: v=%b rs2=%h sd=%h exp 1 4 24", out_valid, alu_rs2, out_store_data); end
    n_checks++;
    if (shifted !== 32'h10)
      begin n_fail++; $display("FAIL shift_result: got %h exp 00000010", shifted); end
    tick();
  endtask

  task automatic test_pc_plus4();
    out_ready = 1'b1;
    drive_beat(32'hDEAD_BEEF, 32'h0, 32'h0, 32'h8000_0100, 2'd1, 2'd2, 1'b0, 5'd0, 3'd3);
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || alu_rs1 !== 32'h8000_0100 || alu_rs2 !== 32'h4)
      begin n_fail++; $display("FAIL pc_plus4: v=%b rs1=%h rs2=%h exp 1 80000100 4", out_valid, alu_rs1, alu_rs2); end
    drive_beat(32'hDEAD_BEEF, 32'h5, 32'h9, 32'h8000_0100, 2'd2, 2'd3, 1'b0, 5'd0, 3'd3);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || alu_rs1 !== 32'h0 || alu_rs2 !== 32'h0)
      begin n_fail++; $display("FAIL zero_sel: v=%b rs1=%h rs2=%h exp 1 0 0", out_valid, alu_rs1, alu_rs2); end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive_beat(32'hA, 32'h0, 32'h0, 32'h0, 2'd0, 2'd3, 1'b0, 5'd0, 3'd0); tick();
    drive_beat(32'hB, 32'h0, 32'h0, 32'h0, 2'd0, 2'd3, 1'b0, 5'd0, 3'd0); tick();
    n_checks++;
    if (out_valid !== 1'b1 || alu_rs1 !== 32'hA || in_ready !== 1'b0)
      begin n_fail++; $display("FAIL bp_full: v=%b rs1=%h rdy=%b exp 1 a 0", out_valid, alu_rs1, in_ready); end
    drive_beat(32'hC, 32'h0, 32'h0, 32'h0, 2'd0, 2'd3, 1'b0, 5'd0, 3'd0); tick();
    n_checks++;
    if (alu_rs1 !== 32'hA || in_ready !== 1'b0)
      begin n_fail++; $display("FAIL bp_hold: rs1=%h rdy=%b exp a 0", alu_rs1, in_ready); end
    out_ready = 1'b1; tick();
    n_checks++;
    if (out_valid !== 1'b1 || alu_rs1 !== 32'hB || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL bp_second: v=%b rs1=%h rdy=%b exp 1 b 1", out_valid, alu_rs1, in_ready); end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || alu_rs1 !== 32'hC)
      begin n_fail++; $display("FAIL bp_third: v=%b rs1=%h exp 1 c", out_valid, alu_rs1); end
    tick();
    n_checks++;
    if (out_valid !== 1'b0)
      begin n_fail++; $display("FAIL bp_drain: out_valid=%b exp 0", out_valid); end
  endtask

  task automatic fill_two_harts();
    out_ready = 1'b0;
    drive_beat(32'h22, 32'h0, 32'h0, 32'h0, 2'd0, 2'd3, 1'b0, 5'd0, 3'd2); tick();
    drive_beat(32'h55, 32'h0, 32'h0, 32'h0, 2'd0, 2'd3, 1'b0, 5'd0, 3'd5); tick();
    in_valid = 1'b0;
  endtask

  task automatic test_flush();
    fill_two_harts();
    flush_valid = 1'b1; flush_hart = 3'd2; tick(); flush_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_hart_id !== 3'd5 || alu_rs1 !== 32'h55 || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL flush_main: v=%b hart=%0d rs1=%h rdy=%b exp 1 5 55 1", out_valid, out_hart_id, alu_rs1, in_ready); end
    out_ready = 1'b1; tick();
    n_checks++;
    if (out_valid !== 1'b0)
      begin n_fail++; $display("FAIL flush_main_drain: out_valid=%b exp 0", out_valid); end
    fill_two_harts();
    flush_valid = 1'b1; flush_hart = 3'd5; tick(); flush_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_hart_id !== 3'd2 || alu_rs1 !== 32'h22 || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL flush_skid: v=%b hart=%0d rs1=%h rdy=%b exp 1 2 22 1", out_valid, out_hart_id, alu_rs1, in_ready); end
    out_ready = 1'b1; tick();
    n_checks++;
    if (out_valid !== 1'b0)
      begin n_fail++; $display("FAIL flush_skid_drain: out_valid=%b exp 0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    fill_two_harts();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    n_checks++;
    if (out_valid !== 1'b0 || alu_rs1 !== 32'h0 || out_hart_id !== 3'h0 || out_rd_we !== 1'b0)
      begin n_fail++; $display("FAIL midreset_outputs: v=%b rs1=%h hart=%0d we=%b exp all 0", out_valid, alu_rs1, out_hart_id, out_rd_we); end
    out_ready = 1'b1; tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin n_fail++; $display("FAIL midreset_stale: rdy=%b v=%b exp 1 0", in_ready, out_valid); end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst_n       = ($urandom_range(0, 99) != 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      flush_valid = ($urandom_range(0, 7) == 0);
      flush_hart  = 3'($urandom_range(0, 3));
      in_rs1_data = $urandom; in_rs2_data = $urandom; in_imm = $urandom; in_pc = $urandom;
      in_op1_sel  = 2'($urandom); in_op2_sel = 2'($urandom); in_is_shift = 1'($urandom);
      in_alu_op   = 5'($urandom); in_hart_id = 3'($urandom_range(0, 3));
      in_rd       = 5'($urandom); in_rd_we = 1'($urandom);
      tick();
      n_checks++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2))
        begin n_fail++; $display("FAIL rand_ctrl@%0d: v=%b rdy=%b model_size=%0d", cyc, out_valid, in_ready, q.size()); end
      if (q.size() > 0) begin
        n_checks++;
        if (alu_rs1 !== q[0].op1 || alu_rs2 !== q[0].op2 || out_store_data !== q[0].store)
          begin n_fail++; $display("FAIL rand_data@%0d: rs1=%h rs2=%h sd=%h exp %h %h %h", cyc, alu_rs1, alu_rs2, out_store_data, q[0].op1, q[0].op2, q[0].store); end
        n_checks++;
        if (alu_opcode !== q[0].op || out_hart_id !== q[0].hart || out_rd !== q[0].rd || out_rd_we !== q[0].we)
          begin n_fail++; $display("FAIL rand_side@%0d: op=%h hart=%0d rd=%0d we=%b exp %h %0d %0d %b", cyc, alu_opcode, out_hart_id, out_rd, out_rd_we, q[0].op, q[0].hart, q[0].rd, q[0].we); end
      end
    end
    rst_n = 1'b1; in_valid = 1'b0; flush_valid = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL rand_drain: v=%b rdy=%b exp 0 1", out_valid, in_ready); end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_shift_mask();
    test_pc_plus4();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
